// File: rtl/localizer_pkg.sv
// Shared types and constants for the localizer frame scheduler.
package localizer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT_ANGLE,
        DROP_REST
    } sched_state_t;

    localparam int CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/localizer_scheduler.sv
// Frame scheduler between the FFT stream and the translate/aggregate datapath.
// Optional frame statistics outputs are enabled by LOCALIZER_SCHED_STATS_EN.
module localizer_scheduler
    import localizer_pkg::*;
#(
    parameter int LOWER_FFT_BOUND = 9,
    parameter int UPPER_FFT_BOUND = 200,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             fft_valid_in,
    input  logic             fft_last_in,
    output logic             fft_ready_out,
    input  logic             xlate_ready_in,
    output logic             xlate_valid_out,
    output logic [7:0]       bin_index_out,
    input  logic             angle_valid_in,
    input  logic [15:0]      angle_in,
    output logic [15:0]      angle_out,
    output logic             angle_valid_out,
    output logic             busy_out,
    output logic             timeout_out,
    output logic             short_frame_out,
`ifdef LOCALIZER_SCHED_STATS_EN
    output logic [CNT_W-1:0] frames_ok_out,
    output logic [CNT_W-1:0] frames_timeout_out,
`endif
    output logic [CNT_W-1:0] dropped_cnt_out
);

    localparam int BIN_W    = $clog2(UPPER_FFT_BOUND) + 1;
    localparam int EXP_BINS = UPPER_FFT_BOUND - LOWER_FFT_BOUND - 1;
    localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);

    sched_state_t     state_reg, state_next;
    logic [BIN_W-1:0] cnt_reg;
    logic [BIN_W-1:0] fwd_cnt_reg;
    logic [BIN_W-1:0] fwd_total;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             frame_open_reg;
    logic [15:0]      angle_reg;
    logic             angle_valid_reg;
    logic             timeout_reg;
    logic             short_reg;

    logic in_window, stream_like, accept, forwarded, frame_end;
    logic tmo_expired, angle_take, tmo_fire, drop_inc;

    // A bin arriving in IDLE is treated exactly as a STREAM bin in the same cycle.
    assign stream_like = (state_reg == STREAM) || ((state_reg == IDLE) && fft_valid_in);
    assign in_window   = (cnt_reg > BIN_W'(LOWER_FFT_BOUND)) && (cnt_reg < BIN_W'(UPPER_FFT_BOUND));

    // Ready is held low while reset is asserted so nothing is consumed during reset.
    assign fft_ready_out   = rst_in && ((stream_like && in_window) ? xlate_ready_in : 1'b1);
    assign xlate_valid_out = stream_like && fft_valid_in && in_window;
    assign bin_index_out   = 8'(cnt_reg);

    assign accept      = fft_valid_in && fft_ready_out;
    assign forwarded   = xlate_valid_out && xlate_ready_in;
    assign frame_end   = accept && fft_last_in;
    assign tmo_expired = (tmo_cnt_reg == '0);
    assign angle_take  = (state_reg == WAIT_ANGLE) && angle_valid_in;
    assign tmo_fire    = (state_reg == WAIT_ANGLE) && !angle_valid_in && tmo_expired;
    assign drop_inc    = (state_reg == WAIT_ANGLE) && accept && !frame_open_reg;
    assign fwd_total   = ((state_reg == IDLE) ? '0 : fwd_cnt_reg) + BIN_W'(forwarded);

    assign angle_out       = angle_reg;
    assign angle_valid_out = angle_valid_reg;
    assign timeout_out     = timeout_reg;
    assign short_frame_out = short_reg;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy_out   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fft_valid_in) begin
                    state_next = frame_end ? WAIT_ANGLE : STREAM;
                end
            end
            STREAM: begin
                busy_out = 1'b1;
                if (frame_end) begin
                    state_next = WAIT_ANGLE;
                end
            end
            WAIT_ANGLE: begin
                busy_out = 1'b1;
                if (angle_valid_in) begin
                    state_next = IDLE;
                end else if (tmo_expired) begin
                    state_next = DROP_REST;
                end
            end
            DROP_REST: begin
                if (!frame_open_reg || frame_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_reg         <= '0;
            frame_open_reg  <= 1'b0;
            fwd_cnt_reg     <= '0;
            short_reg       <= 1'b0;
            tmo_cnt_reg     <= '0;
            angle_reg       <= '0;
            angle_valid_reg <= 1'b0;
            timeout_reg     <= 1'b0;
        end else begin
            if (accept) begin
                frame_open_reg <= !fft_last_in;
                if (fft_last_in) begin
                    cnt_reg <= '0;
                end else if (cnt_reg != BIN_W'(UPPER_FFT_BOUND)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            if (stream_like) begin
                fwd_cnt_reg <= fwd_total;
            end
            if (stream_like && frame_end) begin
                short_reg   <= (fwd_total != BIN_W'(EXP_BINS));
                tmo_cnt_reg <= TMO_W'(TIMEOUT_CYCLES - 1);
            end else if ((state_reg == WAIT_ANGLE) && !tmo_expired) begin
                tmo_cnt_reg <= tmo_cnt_reg - 1'b1;
            end
            angle_valid_reg <= angle_take;
            if (angle_take) begin
                angle_reg   <= angle_in;
                timeout_reg <= 1'b0;
            end else if (tmo_fire) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_dropped (
        .clk   (clk_in),
        .rst_n (rst_in),
        .inc   (drop_inc),
        .clr   (1'b0),
        .count (dropped_cnt_out)
    );

`ifdef LOCALIZER_SCHED_STATS_EN
    sat_counter #(.WIDTH(CNT_W)) u_frames_ok (
        .clk   (clk_in),
        .rst_n (rst_in),
        .inc   (angle_take),
        .clr   (1'b0),
        .count (frames_ok_out)
    );

    sat_counter #(.WIDTH(CNT_W)) u_frames_timeout (
        .clk   (clk_in),
        .rst_n (rst_in),
        .inc   (tmo_fire),
        .clr   (1'b0),
        .count (frames_timeout_out)
    );
`endif

endmodule

// File: tb/tb_localizer_scheduler.sv
// Self-checking bench for localizer_scheduler; frame-level reference model with randomized ready/angles.
module tb_localizer_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        fft_valid_in = 1'b0;
    logic        fft_last_in = 1'b0;
    logic        fft_ready_out;
    logic        xlate_ready_in = 1'b1;
    logic        xlate_valid_out;
    logic [7:0]  bin_index_out;
    logic        angle_valid_in = 1'b0;
    logic [15:0] angle_in = '0;
    logic [15:0] angle_out;
    logic        angle_valid_out;
    logic        busy_out;
    logic        timeout_out;
    logic        short_frame_out;
    logic [15:0] dropped_cnt_out;
`ifdef LOCALIZER_SCHED_STATS_EN
    logic [15:0] frames_ok_out;
    logic [15:0] frames_timeout_out;
`endif

    localparam int TMO     = 100;
    localparam int LOWER   = 9;
    localparam int UPPER   = 200;
    localparam int EXPBINS = UPPER - LOWER - 1;

    localizer_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .fft_valid_in       (fft_valid_in),
        .fft_last_in        (fft_last_in),
        .fft_ready_out      (fft_ready_out),
        .xlate_ready_in     (xlate_ready_in),
        .xlate_valid_out    (xlate_valid_out),
        .bin_index_out      (bin_index_out),
        .angle_valid_in     (angle_valid_in),
        .angle_in           (angle_in),
        .angle_out          (angle_out),
        .angle_valid_out    (angle_valid_out),
        .busy_out           (busy_out),
        .timeout_out        (timeout_out),
        .short_frame_out    (short_frame_out),
`ifdef LOCALIZER_SCHED_STATS_EN
        .frames_ok_out      (frames_ok_out),
        .frames_timeout_out (frames_timeout_out),
`endif
        .dropped_cnt_out    (dropped_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    int          n_checks = 0;
    int          n_fail = 0;
    bit          model_waiting = 0;
    int          exp_dropped = 0;
    logic        exp_short = 0;
    logic [15:0] exp_angle = '0;
    logic        exp_timeout = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fft_ready"}, fft_ready_out, 0);
        check({tag, "_xlate_valid"}, xlate_valid_out, 0);
        check({tag, "_bin_index"}, bin_index_out, 0);
        check({tag, "_angle"}, angle_out, 0);
        check({tag, "_angle_valid"}, angle_valid_out, 0);
        check({tag, "_busy"}, busy_out, 0);
        check({tag, "_timeout"}, timeout_out, 0);
        check({tag, "_short"}, short_frame_out, 0);
        check({tag, "_dropped"}, dropped_cnt_out, 0);
    endtask

    // Drives one frame of n bins; dut_fwd counts handshakes observed on the DUT side.
    task automatic send_frame(input int n, input bit rand_ready, input bit with_last, output int dut_fwd);
        bit fwd_mode;
        int model_fwd;
        fwd_mode  = !model_waiting;
        model_fwd = 0;
        dut_fwd   = 0;
        for (int k = 0; k < n; k++) begin
            bit done;
            int tries;
            done  = 0;
            tries = 0;
            while (!done) begin
                int ks;
                bit win;
                bit xr;
                @(negedge clk_in);
                ks = (k > UPPER) ? UPPER : k;
                win = fwd_mode && (ks > LOWER) && (ks < UPPER);
                xr = (rand_ready && tries < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
                fft_valid_in   = 1'b1;
                fft_last_in    = with_last && (k == n - 1);
                xlate_ready_in = xr;
                #1;
                check("fft_ready", fft_ready_out, win ? xr : 1'b1);
                check("xlate_valid", xlate_valid_out, win);
                if (win) check("bin_index", bin_index_out, ks);
                if (xlate_valid_out && xlate_ready_in) dut_fwd++;
                if (win && xr) model_fwd++;
                done = !win || xr;
                tries++;
                @(posedge clk_in);
            end
        end
        #1;
        fft_valid_in   = 1'b0;
        fft_last_in    = 1'b0;
        xlate_ready_in = 1'b1;
        if (with_last) begin
            if (fwd_mode) begin
                model_waiting = 1;
                exp_short = (model_fwd != EXPBINS);
            end else if (exp_dropped < 65535) begin
                exp_dropped++;
            end
            check("short_frame", short_frame_out, exp_short);
            check("busy_wait", busy_out, 1);
            check("dropped_cnt", dropped_cnt_out, exp_dropped);
        end
        $display("frame: bins=%0d forwarded=%0d short=%0b dropped=%0d", n, dut_fwd, short_frame_out, dropped_cnt_out);
    endtask

    // Strobes an angle on the delay-th clock edge after the call.
    task automatic give_angle(input int delay, input logic [15:0] val);
        bit exp_pulse;
        repeat (delay - 1) @(posedge clk_in);
        @(negedge clk_in);
        angle_valid_in = 1'b1;
        angle_in       = val;
        @(posedge clk_in);
        #1;
        angle_valid_in = 1'b0;
        angle_in       = 16'($urandom);
        exp_pulse = model_waiting;
        if (model_waiting) begin
            exp_angle     = val;
            exp_timeout   = 0;
            model_waiting = 0;
        end
        check("angle_valid_pulse", angle_valid_out, exp_pulse);
        check("angle_out", angle_out, exp_angle);
        check("timeout_after_angle", timeout_out, exp_timeout);
        check("busy_after_angle", busy_out, 0);
        check("dropped_after_angle", dropped_cnt_out, exp_dropped);
        @(posedge clk_in);
        #1;
        check("angle_valid_end", angle_valid_out, 0);
        $display("angle: value=%04h taken=%0b angle_out=%04h timeout=%0b", val, exp_pulse, angle_out, timeout_out);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fwd;

        #2 rst_in = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Full 256-bin frame, angle returned 20 cycles after last.
        send_frame(256, 0, 1, fwd);
        check("s1_fwd_count", fwd, EXPBINS);
        give_angle(20, 16'h1234);

        // Randomly stalling translate stage.
        send_frame(256, 1, 1, fwd);
        check("s2_fwd_count", fwd, EXPBINS);
        give_angle($urandom_range(2, 60), 16'($urandom));

        // Frame arriving during WAIT_ANGLE is dropped, following frame is normal.
        send_frame(256, 0, 1, fwd);
        check("s3a_fwd_count", fwd, EXPBINS);
        send_frame(40, 0, 1, fwd);
        check("s3b_fwd_count", fwd, 0);
        give_angle(10, 16'($urandom));
        send_frame(256, 1, 1, fwd);
        check("s3c_fwd_count", fwd, EXPBINS);
        give_angle($urandom_range(1, 90), 16'($urandom));

        // Angle strobe outside WAIT_ANGLE is ignored.
        give_angle(3, 16'hBEEF);

        // One-bin frame, no angle: timeout after exactly TMO cycles.
        send_frame(1, 0, 1, fwd);
        check("s4_fwd_count", fwd, 0);
        for (int i = 1; i <= TMO; i++) begin
            @(posedge clk_in);
            #1;
            check("s4_timeout", timeout_out, (i == TMO));
            check("s4_busy", busy_out, (i < TMO));
        end
        model_waiting = 0;
        exp_timeout   = 1;
        @(posedge clk_in);
        #1;
        check("s4_idle_busy", busy_out, 0);
        give_angle(2, 16'h5A5A);
        $display("timeout: timeout_out=%0b busy=%0b", timeout_out, busy_out);

        // Short frame, then a good angle clears the timeout flag.
        send_frame(50, 0, 1, fwd);
        check("s5_fwd_count", fwd, 40);
        give_angle($urandom_range(1, 90), 16'($urandom));

        // Reset in the middle of a frame.
        send_frame(120, 1, 0, fwd);
        @(negedge clk_in);
        fft_valid_in = 1'b1;
        rst_in       = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_waiting = 0;
        exp_dropped   = 0;
        exp_short     = 0;
        exp_angle     = '0;
        exp_timeout   = 0;
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in       = 1'b1;
        fft_valid_in = 1'b0;
        $display("reset: mid-frame reset applied and released");
        send_frame(256, 0, 1, fwd);
        check("s6_fwd_count", fwd, EXPBINS);
        give_angle(20, 16'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
